instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0000, instruction word presented on a bubble.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  from decode; ID stage must hold its instruction.
REQ-006 jump_branch  in  1  from decode; conditional branch taken.
REQ-007 jump_target  in  1  from decode; J/JAL in ID.
REQ-008 jump_reg  in  1  from decode; JR/JALR in ID.
REQ-009 jr_pc  in  32  from decode; forwarded rs value for register jumps.
REQ-010 imem_req  out  1  instruction memory request.
REQ-011 imem_addr  out  32  word address of request (pc_if).
REQ-012 imem_ack  in  1  request complete; imem_rdata valid this cycle.
REQ-013 imem_rdata  in  32  fetched instruction.
REQ-014 pc_id  out  32  registered PC of instruction in ID.
REQ-015 instr_id  out  32  registered instruction in ID.
REQ-016 instr_valid_id  out  1  instr_id is a real instruction, not a bubble.

Function
REQ-017 States: FETCH (imem_req=1, request for pc_if outstanding) and BUFFERED (imem_req=0, one fetched instruction held in skid buffer buf_instr/buf_pc).
REQ-018 imem_req and imem_addr=pc_if held stable until imem_ack; imem_ack with imem_req=0 ignored; imem_req=0 whenever rst=1.
REQ-019 FETCH, ack, stall=0: instr_id<=imem_rdata, pc_id<=pc_if, instr_valid_id<=1, pc_if<=next_pc, remain FETCH (back-to-back requests, 1 instr/cycle at 1-cycle ack).
REQ-020 FETCH, ack, stall=1: buffer<=(imem_rdata, pc_if), pc_if<=next_pc, go BUFFERED; ID registers hold.
REQ-021 FETCH, no ack, stall=0: instr_id<=NOP_INSTR, instr_valid_id<=0, pc_id holds.
REQ-022 Any state, stall=1: pc_id, instr_id, instr_valid_id hold.
REQ-023 BUFFERED, stall=0: ID<=buffer, instr_valid_id<=1, go FETCH with imem_addr=pc_if next cycle.
REQ-024 Fetch runs at most one instruction ahead of ID (outstanding request or buffer, never both).
REQ-025 Redirect accepted only when instr_valid_id=1, stall=0 and (jump_branch|jump_target|jump_reg); ignored otherwise.
REQ-026 Target: jump_reg -> jr_pc; jump_target -> {pc_id[31:28]+0 of (pc_id+4)[31:28], instr_id[25:0], 2'b00}; jump_branch -> pc_id+4+({{14{instr_id[15]}},instr_id[15:0],2'b00}); priority jump_reg > jump_target > jump_branch; 32-bit wrap-around arithmetic.
REQ-027 Delay slot: instruction at pc_id+4 always delivered to ID after the branch/jump.
REQ-028 Redirect while delay slot in flight (FETCH): target saved in redirect_pc, redirect_pending<=1; next_pc on that ack = redirect_pc, pending cleared.
REQ-029 Redirect in same cycle as delay-slot ack: next_pc = target directly; pending not set.
REQ-030 Redirect while delay slot buffered (BUFFERED): pc_if<=target immediately.
REQ-031 Otherwise next_pc = pc_if+4.
REQ-032 Low two bits of pc_if not checked; passed through.

Reset
REQ-033 rst=1: pc_if<=RESET_PC, state<=FETCH, redirect_pending<=0, buffer cleared, pc_id<=0, instr_id<=NOP_INSTR, instr_valid_id<=0; imem_req=0 during reset cycle.
REQ-034 rst mid-request discards outstanding fetch and pending redirect; first request after reset is RESET_PC.

Verification
REQ-035 Reset, 1-cycle ack -> imem_addr 0x0,0x4,0x8 consecutive cycles; instr_id follows one cycle later, valid=1.
REQ-036 Ack latency 3 -> two bubble cycles per instr (valid=0, instr_id=0x0), pc_id unchanged.
REQ-037 Stall=1 two cycles with ack on first -> BUFFERED, imem_req=0; on release buffered instr reaches ID, next request pc+4.
REQ-038 BEQ at pc_id=0x10, imm 0x0004, jump_branch=1 -> delay slot 0x14 delivered, next imem_addr 0x24.
REQ-039 JR, jr_pc=0x100, delay slot buffered -> delay slot delivered, next imem_addr 0x100; same with stall=1 -> no redirect.
REQ-040 rst during outstanding request to 0x40 -> imem_req=0 in reset cycle, next request 0x0, valid=0.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : IF stage with a one-entry skid buffer. The fetch runs at most
//               one instruction ahead of ID. Taken branches and jumps
//               redirect the fetch after the delay slot.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        instr_valid_id
);

    localparam logic [0:0] c_st_fetch    = 1'b0;
    localparam logic [0:0] c_st_buffered = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc_if;
    logic        r_redirect_pending;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_pc_id;
    logic [31:0] r_instr_id;
    logic        r_valid_id;

    logic        w_redirect;
    logic [31:0] w_pc_id_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    // A redirect is only honoured for a real, advancing branch in ID.
    assign w_redirect    = r_valid_id & ~stall & (jump_branch | jump_target | jump_reg);
    assign w_pc_id_plus4 = r_pc_id + 32'd4;
    assign w_br_off      = {{14{r_instr_id[15]}}, r_instr_id[15:0], 2'b00};
    assign w_target      = jump_reg    ? jr_pc :
                           jump_target ? {w_pc_id_plus4[31:28], r_instr_id[25:0], 2'b00} :
                                         w_pc_id_plus4 + w_br_off;
    assign w_next_pc     = r_redirect_pending ? r_redirect_pc :
                           w_redirect         ? w_target      :
                                                r_pc_if + 32'd4;

    assign imem_req       = ~rst & (r_state == c_st_fetch);
    assign imem_addr      = r_pc_if;
    assign pc_id          = r_pc_id;
    assign instr_id       = r_instr_id;
    assign instr_valid_id = r_valid_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= c_st_fetch;
            r_pc_if            <= RESET_PC;
            r_redirect_pending <= 1'b0;
            r_redirect_pc      <= 32'd0;
            r_buf_instr        <= NOP_INSTR;
            r_buf_pc           <= 32'd0;
            r_pc_id            <= 32'd0;
            r_instr_id         <= NOP_INSTR;
            r_valid_id         <= 1'b0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (imem_ack) begin
                        r_pc_if            <= w_next_pc;
                        r_redirect_pending <= 1'b0;
                        if (stall) begin
                            r_buf_instr <= imem_rdata;
                            r_buf_pc    <= r_pc_if;
                            r_state     <= c_st_buffered;
                        end else begin
                            r_instr_id <= imem_rdata;
                            r_pc_id    <= r_pc_if;
                            r_valid_id <= 1'b1;
                        end
                    end else begin
                        if (!stall) begin
                            r_instr_id <= NOP_INSTR;
                            r_valid_id <= 1'b0;
                        end
                        // Delay slot still in flight: remember where to go after it.
                        if (w_redirect) begin
                            r_redirect_pending <= 1'b1;
                            r_redirect_pc      <= w_target;
                        end
                    end
                end
                c_st_buffered: begin
                    if (!stall) begin
                        r_instr_id <= r_buf_instr;
                        r_pc_id    <= r_buf_pc;
                        r_valid_id <= 1'b1;
                        r_state    <= c_st_fetch;
                        if (w_redirect) begin
                            r_pc_if <= w_target;
                        end
                    end
                end
                default: r_state <= c_st_fetch;
            endcase
        end
    end

endmodule
`default_nettype wire
